// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin arbiter sharing one UART TX byte
// channel among NUM_CH requesters. A grant lasts for a whole packet (until a
// byte with last=1 transfers), an optional channel-ID header byte leads each
// packet, and a watchdog drops ownership when the owner stalls mid-packet.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner; arbitrate among req_valid_i starting after ptr
// HDR   | owner chosen; present HEADER_BASE | ptr until tx accepts it
// DATA  | owner's byte stream forwarded to tx; ends on last or timeout
`timescale 1ns/1ps

module uart_tx_arbiter #(
    parameter int          NUM_CH      = 4,
    parameter bit          ADD_HEADER  = 1'b1,
    parameter logic [7:0]  HEADER_BASE = 8'hA0,
    parameter logic [31:0] TIMEOUT     = 32'd1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     req_valid_i,
    input  logic [NUM_CH*8-1:0]   req_data_i,
    input  logic [NUM_CH-1:0]     req_last_i,
    output logic [NUM_CH-1:0]     req_ready_o,
    output logic                  tx_valid_o,
    output logic [7:0]            tx_data_o,
    input  logic                  tx_ready_i,
    output logic [NUM_CH-1:0]     grant_o,
    output logic                  busy_o,
    output logic                  abort_o
);

    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t            state;
    logic [PW-1:0]     ptr;        // last granted channel; also current owner index
    logic [NUM_CH-1:0] grant;
    logic [31:0]       wdog_cnt;
    logic              abort;

    logic [7:0]        ch_data [NUM_CH];
    logic              g_valid;
    logic              g_last;
    logic [7:0]        g_data;

    logic              sel_found;
    logic [PW-1:0]     sel_idx;
    logic [PW-1:0]     cand;

    // Unpack the flat data bus into per-channel bytes
    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign ch_data[k] = req_data_i[8*k +: 8];
    end

    // The owner is always ptr once a grant is made, so ptr doubles as the mux select
    assign g_valid = req_valid_i[ptr];
    assign g_last  = req_last_i[ptr];
    assign g_data  = ch_data[ptr];

    // Round-robin search: scan from the farthest offset down so the nearest
    // requester after ptr is the one left in sel_idx
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int off = NUM_CH; off >= 1; off--) begin
            cand = PW'((int'(ptr) + off) % NUM_CH);
            if (req_valid_i[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Packet FSM with grant register, round-robin pointer and stall watchdog
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            ptr      <= PW'(NUM_CH - 1);
            wdog_cnt <= '0;
            abort    <= 1'b0;
        end else begin
            abort <= 1'b0;
            case (state)
                IDLE: begin
                    wdog_cnt <= '0;
                    if (sel_found) begin
                        grant <= NUM_CH'(1) << sel_idx;
                        ptr   <= sel_idx;
                        state <= ADD_HEADER ? HDR : DATA;
                    end
                end
                HDR: begin
                    wdog_cnt <= '0;
                    if (tx_ready_i) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (g_valid) begin
                        // Any valid cycle, including backpressured ones, proves the owner is alive
                        wdog_cnt <= '0;
                        if (tx_ready_i && g_last) begin
                            state <= IDLE;
                            grant <= '0;
                        end
                    end else if (TIMEOUT != 32'd0) begin
                        if (wdog_cnt + 32'd1 == TIMEOUT) begin
                            // ptr keeps the stalled owner so it drops to lowest priority
                            abort    <= 1'b1;
                            state    <= IDLE;
                            grant    <= '0;
                            wdog_cnt <= '0;
                        end else begin
                            wdog_cnt <= wdog_cnt + 32'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    // Datapath steering; tx_valid_o follows state and owner valid only, never tx_ready_i
    always_comb begin
        tx_valid_o  = 1'b0;
        tx_data_o   = '0;
        req_ready_o = '0;
        case (state)
            HDR: begin
                tx_valid_o = 1'b1;
                tx_data_o  = HEADER_BASE | 8'(ptr);
            end
            DATA: begin
                tx_valid_o       = g_valid;
                tx_data_o        = g_data;
                req_ready_o[ptr] = tx_ready_i;
            end
            default: begin
                tx_valid_o  = 1'b0;
                tx_data_o   = '0;
                req_ready_o = '0;
            end
        endcase
    end

    assign grant_o = grant;
    assign busy_o  = (state != IDLE);
    assign abort_o = abort;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: instance A (header on, TIMEOUT=8) and instance B
// (no header, watchdog off). Per-channel byte tables feed both; expected UART
// bytes are queued at stimulus time and popped by an independent monitor.
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [7:0]  rv_all, rl_all, rdy_all;
    logic [63:0] rd_all;
    logic [3:0]  rdy_a, rdy_b, grant_a, grant_b;
    logic        txv_a, txv_b, busy_a, busy_b, abort_a, abort_b, tra, trb;
    logic [7:0]  txd_a, txd_b;

    // Driver tables: channels 0..3 feed DUT A, 4..7 feed DUT B
    logic [8:0]  mem [8][32];
    logic [5:0]  len [8];
    logic [5:0]  pos [8];
    bit          hs  [8];

    logic [7:0]  exp_a [$];
    logic [7:0]  exp_b [$];
    logic [7:0]  e_a, e_b;
    int          n_tests = 0;
    int          n_fail  = 0;

    for (genvar c = 0; c < 8; c++) begin : g_drv
        assign rv_all[c]         = (pos[c] < len[c]);
        assign rd_all[8*c +: 8]  = mem[c][pos[c][4:0]][7:0];
        assign rl_all[c]         = mem[c][pos[c][4:0]][8];
    end
    assign rdy_all = {rdy_b, rdy_a};

    uart_tx_arbiter #(.NUM_CH(4), .ADD_HEADER(1'b1), .HEADER_BASE(8'hA0), .TIMEOUT(32'd8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(rv_all[3:0]), .req_data_i(rd_all[31:0]), .req_last_i(rl_all[3:0]),
        .req_ready_o(rdy_a), .tx_valid_o(txv_a), .tx_data_o(txd_a), .tx_ready_i(tra),
        .grant_o(grant_a), .busy_o(busy_a), .abort_o(abort_a)
    );

    uart_tx_arbiter #(.NUM_CH(4), .ADD_HEADER(1'b0), .HEADER_BASE(8'hA0), .TIMEOUT(32'd0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(rv_all[7:4]), .req_data_i(rd_all[63:32]), .req_last_i(rl_all[7:4]),
        .req_ready_o(rdy_b), .tx_valid_o(txv_b), .tx_data_o(txd_b), .tx_ready_i(trb),
        .grant_o(grant_b), .busy_o(busy_b), .abort_o(abort_b)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int c, input logic [7:0] d, input logic l);
        mem[c][len[c][4:0]] = {l, d};
        len[c] = len[c] + 6'd1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 60) begin
            tick();
            n++;
        end
        chk("drain_a", exp_a.size(), 0);
        chk("drain_b", exp_b.size(), 0);
        tick();
        tick();
    endtask

    // Requester handshake capture, away from the active edge
    always @(negedge clk) begin
        for (int c = 0; c < 8; c++) hs[c] = rst_n && rv_all[c] && rdy_all[c];
    end

    // Requester advance after each accepted byte
    always @(posedge clk) begin
        #1;
        for (int c = 0; c < 8; c++) if (hs[c]) pos[c] = pos[c] + 6'd1;
    end

    // Scoreboard monitor: every UART handshake must match the next queued byte
    always @(negedge clk) begin
        if (rst_n) begin
            if (txv_a && tra) begin
                n_tests++;
                if (exp_a.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_a: unexpected byte %0h, none required", txd_a);
                end else begin
                    e_a = exp_a.pop_front();
                    if (txd_a !== e_a) begin
                        n_fail++;
                        $display("FAIL sb_a: got %0h expected %0h", txd_a, e_a);
                    end
                end
            end
            if (txv_b && trb) begin
                n_tests++;
                if (exp_b.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_b: unexpected byte %0h, none required", txd_b);
                end else begin
                    e_b = exp_b.pop_front();
                    if (txd_b !== e_b) begin
                        n_fail++;
                        $display("FAIL sb_b: got %0h expected %0h", txd_b, e_b);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] p1 [5];
        logic [7:0] p2 [19];
        logic [7:0] p3 [7];
        logic [6:0] v3, r3, v5, r5;
        logic [7:0] p5 [7];
        logic [3:0] g5 [7];

        p1 = '{8'h00, 8'hA2, 8'h11, 8'h22, 8'h33};
        p2 = '{8'h00, 8'hA0, 8'h10, 8'h00, 8'hA3, 8'h30, 8'h00, 8'hA0, 8'h11, 8'h00,
               8'hA3, 8'h31, 8'h00, 8'hA0, 8'h12, 8'h00, 8'hA3, 8'h32, 8'h00};
        p3 = '{8'h00, 8'hA1, 8'h55, 8'h55, 8'h66, 8'h66, 8'h00};
        v3 = 7'b0111110;   // bit i = expected tx_valid in cycle i
        r3 = 7'b0101000;   // bit i = expected req_ready_o[1]
        p5 = '{8'h00, 8'hAA, 8'hBB, 8'h00, 8'hC1, 8'hC2, 8'h00};
        v5 = 7'b0110110;
        r5 = 7'b0110000;
        g5 = '{4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0010, 4'b0010, 4'b0000};

        rst_n = 1'b0;
        tra   = 1'b1;
        trb   = 1'b1;
        for (int c = 0; c < 8; c++) begin
            len[c] = '0;
            pos[c] = '0;
        end
        tick();
        tick();
        at_neg();
        chk("rst_tx_valid", txv_a, 0);
        chk("rst_tx_data", txd_a, 0);
        chk("rst_grant", grant_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_abort", abort_a, 0);
        chk("rst_req_ready", rdy_a, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Test 1: ch2 packet with header, then a second one cut by reset
        push(2, 8'h11, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h33, 1'b1);
        exp_a.push_back(8'hA2); exp_a.push_back(8'h11);
        exp_a.push_back(8'h22); exp_a.push_back(8'h33);
        for (int i = 0; i < 5; i++) begin
            at_neg();
            chk("t1_valid", txv_a, (i > 0));
            if (i > 0) begin
                chk("t1_data", txd_a, p1[i]);
                chk("t1_grant", grant_a, 4'b0100);
            end
            tick();
        end
        push(2, 8'h11, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h33, 1'b1);
        exp_a.push_back(8'hA2); exp_a.push_back(8'h11); exp_a.push_back(8'h22);
        at_neg();
        chk("t1_gap_busy", busy_a, 0);
        tick();   // header
        tick();   // 0x11
        tick();   // 0x22
        tick();
        rst_n = 1'b0;
        tick();
        rst_n  = 1'b1;
        pos[2] = len[2];
        push(3, 8'h3C, 1'b1);
        push(0, 8'h0C, 1'b1);
        exp_a.push_back(8'hA0); exp_a.push_back(8'h0C);
        exp_a.push_back(8'hA3); exp_a.push_back(8'h3C);
        at_neg();
        chk("t1_post_rst_valid", txv_a, 0);
        chk("t1_post_rst_grant", grant_a, 0);
        chk("t1_post_rst_busy", busy_a, 0);
        chk("t1_post_rst_ready", rdy_a, 0);
        tick();
        at_neg();
        chk("t1_ch0_first_grant", grant_a, 4'b0001);
        chk("t1_ch0_first_hdr", txd_a, 8'hA0);
        drain();

        // Test 2: ch0 and ch3 alternate 1-byte packets with one idle cycle between
        push(0, 8'h10, 1'b1); push(0, 8'h11, 1'b1); push(0, 8'h12, 1'b1);
        push(3, 8'h30, 1'b1); push(3, 8'h31, 1'b1); push(3, 8'h32, 1'b1);
        for (int i = 0; i < 19; i++) begin
            if (i % 3 != 0) exp_a.push_back(p2[i]);
        end
        for (int i = 0; i < 19; i++) begin
            at_neg();
            chk("t2_valid", txv_a, (i % 3 != 0));
            chk("t2_busy", busy_a, (i % 3 != 0));
            if (i % 3 != 0) chk("t2_data", txd_a, p2[i]);
            tick();
        end
        drain();

        // Test 3: ch1 packet under alternating backpressure
        exp_a.push_back(8'hA1); exp_a.push_back(8'h55); exp_a.push_back(8'h66);
        for (int i = 0; i < 7; i++) begin
            tra = (i % 2 == 1);
            if (i == 0) begin
                push(1, 8'h55, 1'b0);
                push(1, 8'h66, 1'b1);
            end
            at_neg();
            chk("t3_valid", txv_a, v3[i]);
            if (v3[i]) chk("t3_data", txd_a, p3[i]);
            chk("t3_ready1", rdy_a[1], r3[i]);
            chk("t3_ready_others", {rdy_a[3:2], rdy_a[0]}, 0);
            tick();
        end
        tra = 1'b1;
        drain();

        // Test 4: ch0 stalls after one byte; watchdog hands over to ch1
        push(0, 8'h01, 1'b0);
        push(1, 8'h77, 1'b1);
        exp_a.push_back(8'hA0); exp_a.push_back(8'h01);
        exp_a.push_back(8'hA1); exp_a.push_back(8'h77);
        for (int i = 0; i < 15; i++) begin
            at_neg();
            chk("t4_abort", abort_a, (i == 11));
            if (i == 10) begin
                chk("t4_stall_busy", busy_a, 1);
                chk("t4_stall_grant", grant_a, 4'b0001);
            end
            if (i == 11) begin
                chk("t4_abort_busy", busy_a, 0);
                chk("t4_abort_grant", grant_a, 0);
            end
            if (i == 12) begin
                chk("t4_next_grant", grant_a, 4'b0010);
                chk("t4_next_hdr", txd_a, 8'hA1);
            end
            tick();
        end
        drain();

        // Test 5: no-header instance, ch1 waits behind ch3
        exp_b.push_back(8'hAA); exp_b.push_back(8'hBB);
        exp_b.push_back(8'hC1); exp_b.push_back(8'hC2);
        for (int i = 0; i < 7; i++) begin
            if (i == 0) begin
                push(7, 8'hAA, 1'b0);
                push(7, 8'hBB, 1'b1);
            end
            if (i == 1) begin
                push(5, 8'hC1, 1'b0);
                push(5, 8'hC2, 1'b1);
            end
            at_neg();
            chk("t5_valid", txv_b, v5[i]);
            if (v5[i]) chk("t5_data", txd_b, p5[i]);
            chk("t5_ready1", rdy_b[1], r5[i]);
            chk("t5_grant", grant_b, g5[i]);
            tick();
        end
        drain();
        chk("end_abort_b", abort_b, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
